// File: rtl/jk_bank_pkg.sv
// jk_bank_pkg: JK command encodings and apply-stage states shared by the bank arbiter.
package jk_bank_pkg;
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_CLR  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;
    typedef enum logic {ST_EMPTY, ST_FULL} apply_st_t;
endpackage

// File: rtl/jk_bank_arbiter_if.sv
// jk_bank_arbiter_if: requester command handshake plus bank status outputs.
interface jk_bank_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDXW  = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    parameter int GIDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [2*NREQ-1:0]    req_jk;
    logic [IDXW*NREQ-1:0] req_idx;
    logic [WIDTH-1:0]     q_out;
    logic [WIDTH-1:0]     qb_out;
    logic [GIDW-1:0]      gnt_id;
    logic                 busy_apply;
    logic                 idx_err;
    modport master (
        output req_valid, req_jk, req_idx,
        input  req_ready, q_out, qb_out, gnt_id, busy_apply, idx_err
    );
    modport slave (
        input  req_valid, req_jk, req_idx,
        output req_ready, q_out, qb_out, gnt_id, busy_apply, idx_err
    );
endinterface

// File: rtl/jk_bank_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin grant over NREQ requesters; with prio0 set, requester 0
// wins whenever valid and its grants leave the pointer alone.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int GIDW = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            prio0,
    input  logic [NREQ-1:0] valid,
    output logic [NREQ-1:0] gnt,
    output logic [GIDW-1:0] gid,
    output logic            any
);
    logic [GIDW-1:0] ptr;
    // Outer loop walks positions from the pointer, so the first hit is the winner.
    always_comb begin
        gnt = '0;
        gid = '0;
        any = 1'b0;
        if (!rst && prio0 && valid[0]) begin
            gnt[0] = 1'b1;
            any = 1'b1;
        end
        for (int i = 0; i < NREQ; i++)
            for (int r = 0; r < NREQ; r++)
                if (!rst && !any && valid[r] && r == (int'(ptr) + i) % NREQ) begin
                    gnt[r] = 1'b1;
                    gid = GIDW'(r);
                    any = 1'b1;
                end
    end
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (any && !(prio0 && gnt[0]))
            ptr <= (int'(gid) == NREQ - 1) ? '0 : gid + 1'b1;
    end
endmodule

// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: NREQ requesters share a WIDTH-bit JK bank through a round-robin
// arbiter and a one-deep apply stage. Define JK_ARB_PRIO0_EN to give requester 0 absolute priority.
module jk_bank_arbiter
    import jk_bank_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDXW  = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    parameter int GIDW  = $clog2(NREQ)
) (
    input logic clk,
    input logic rst,
    jk_bank_arbiter_if.slave bus
);
    logic            prio0;
    logic [NREQ-1:0] gnt;
    logic [GIDW-1:0] gid;
    logic            any;
    apply_st_t       st, st_nxt;
    logic [1:0]      a_jk;
    logic [IDXW-1:0] a_idx;
    logic [WIDTH-1:0] q, q_nxt;
`ifdef JK_ARB_PRIO0_EN
    assign prio0 = 1'b1;
`else
    assign prio0 = 1'b0;
`endif
    rr_arbiter #(.NREQ(NREQ), .GIDW(GIDW)) u_arb (
        .clk(clk), .rst(rst), .prio0(prio0), .valid(bus.req_valid),
        .gnt(gnt), .gid(gid), .any(any)
    );
    assign bus.req_ready  = gnt;
    assign bus.gnt_id     = gid;
    assign bus.busy_apply = st == ST_FULL;
    assign bus.idx_err    = st == ST_FULL && int'(a_idx) >= WIDTH;
    assign bus.q_out      = q;
    assign bus.qb_out     = ~q;
    // The stage never stalls: it is full exactly when a command was taken last cycle.
    always_comb st_nxt = any ? ST_FULL : ST_EMPTY;
    always_comb begin
        q_nxt = q;
        for (int b = 0; b < WIDTH; b++)
            if (st == ST_FULL && int'(a_idx) == b)
                q_nxt[b] = a_jk == JK_TGL ? ~q[b] : a_jk == JK_SET ? 1'b1 : a_jk == JK_CLR ? 1'b0 : q[b];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            st    <= ST_EMPTY;
            a_jk  <= JK_HOLD;
            a_idx <= '0;
            q     <= '0;
        end else begin
            st <= st_nxt;
            q  <= q_nxt;
            if (any) begin
                a_jk  <= bus.req_jk[2*gid +: 2];
                a_idx <= bus.req_idx[IDXW*gid +: IDXW];
            end
        end
    end
endmodule

// File: tb/tb_jk_bank_arbiter.sv
// tb_jk_bank_arbiter: directed stimulus with a scoreboard queue of expected grants/bank values.
module tb_jk_bank_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jk_bank_arbiter_if #(.NREQ(4), .WIDTH(8), .IDXW(4), .GIDW(2)) bus ();
    jk_bank_arbiter #(.NREQ(4), .WIDTH(8), .IDXW(4), .GIDW(2)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );

    typedef struct packed {
        logic [1:0] gid;
        logic       err;
        logic [7:0] q;
    } exp_t;
    exp_t sb[$];
    int total = 0;
    int bad = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic push(logic [1:0] g, logic er, logic [7:0] qv);
        sb.push_back({g, er, qv});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(int r, logic v, logic [1:0] jk, logic [3:0] idx);
        bus.req_valid[r] = v;
        bus.req_jk[2*r +: 2] = jk;
        bus.req_idx[4*r +: 4] = idx;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = '1;
        bus.req_jk = '1;
        bus.req_idx = '0;
        step();
        step();
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_q", bus.q_out, 0);
        chk("rst_qb", bus.qb_out, 8'hFF);
        chk("rst_busy", bus.busy_apply, 0);
        chk("rst_idx_err", bus.idx_err, 0);
        chk("rst_gnt_id", bus.gnt_id, 0);
        rst = 1'b0;
        bus.req_valid = '0;
    endtask

    // Monitor: ready/gnt_id seen in one cycle are matched against the entry popped
    // when the apply stage shows busy the next cycle; q_out is checked one cycle later.
    initial begin
        logic [1:0] obs_gid;
        logic [3:0] obs_rdy;
        logic       q_pend;
        logic [7:0] q_exp, qb_exp;
        exp_t       e;
        obs_gid = '0;
        obs_rdy = '0;
        q_pend = 1'b0;
        q_exp = '0;
        forever begin
            @(negedge clk);
            if (q_pend) begin
                qb_exp = ~q_exp;
                chk("q_out", bus.q_out, q_exp);
                chk("qb_out", bus.qb_out, qb_exp);
                q_pend = 1'b0;
            end
            if (!rst) begin
                if (bus.busy_apply) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_apply: busy_apply=1 with no expected command at %0t", $time);
                    end else begin
                        e = sb.pop_front();
                        chk("gnt_id", obs_gid, e.gid);
                        chk("req_ready", obs_rdy, 4'b0001 << e.gid);
                        chk("idx_err", bus.idx_err, e.err);
                        q_exp = e.q;
                        q_pend = 1'b1;
                    end
                end else
                    chk("idx_err_idle", bus.idx_err, 0);
                obs_gid = bus.gnt_id;
                obs_rdy = bus.req_ready;
            end
        end
    end

    initial begin
        bus.req_valid = '0;
        bus.req_jk = '0;
        bus.req_idx = '0;
        // 1: single set of bit 3
        do_reset();
        drv(0, 1, 2'b10, 3); push(0, 0, 8'h08);
        step();
        drv(0, 0, 2'b00, 0);
        step(); step();
        // 2: all four toggle their own bit
        do_reset();
        for (int r = 0; r < 4; r++) drv(r, 1, 2'b11, 4'(r));
`ifdef JK_ARB_PRIO0_EN
        push(0, 0, 8'h01); push(0, 0, 8'h00); push(0, 0, 8'h01); push(0, 0, 8'h00); push(0, 0, 8'h01);
`else
        push(0, 0, 8'h01); push(1, 0, 8'h03); push(2, 0, 8'h07); push(3, 0, 8'h0F); push(0, 0, 8'h0E);
`endif
        repeat (5) step();
        bus.req_valid = '0;
        step(); step();
        // 3: set, toggle, toggle of bit 5 back to back
        do_reset();
        drv(1, 1, 2'b10, 5); push(1, 0, 8'h20); step();
        drv(1, 1, 2'b11, 5); push(1, 0, 8'h00); step();
        drv(1, 1, 2'b11, 5); push(1, 0, 8'h20); step();
        drv(1, 0, 2'b00, 0);
        step(); step();
        // 4: out-of-range index, then pointer must sit at 3
        drv(2, 1, 2'b11, 9); push(2, 1, 8'h20); step();
        drv(2, 0, 2'b00, 0);
        drv(3, 1, 2'b10, 0);
        drv(0, 1, 2'b10, 7);
`ifdef JK_ARB_PRIO0_EN
        push(0, 0, 8'hA0); step();
        drv(0, 0, 2'b00, 0); push(3, 0, 8'hA1); step();
        drv(3, 0, 2'b00, 0);
`else
        push(3, 0, 8'h21); step();
        drv(3, 0, 2'b00, 0); push(0, 0, 8'hA1); step();
        drv(0, 0, 2'b00, 0);
`endif
        step(); step();
        // 5: fill bank, accept a clear, reset discards it
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drv(0, 1, 2'b10, 4'(i));
            push(0, 0, 8'((16'h1 << (i + 1)) - 1));
            step();
        end
        drv(0, 1, 2'b01, 0);
        step();
        drv(0, 0, 2'b00, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_q", bus.q_out, 0);
        chk("mid_rst_busy", bus.busy_apply, 0);
        drv(0, 1, 2'b10, 2);
        drv(1, 1, 2'b10, 1);
        push(0, 0, 8'h04); step();
        drv(0, 0, 2'b00, 0); push(1, 0, 8'h06); step();
        drv(1, 0, 2'b00, 0);
        step(); step();
        // 6: req0 and req1 contend for three cycles, then req1 alone
        do_reset();
        drv(0, 1, 2'b10, 0);
        drv(1, 1, 2'b10, 1);
`ifdef JK_ARB_PRIO0_EN
        push(0, 0, 8'h01); push(0, 0, 8'h01); push(0, 0, 8'h01); push(1, 0, 8'h03);
`else
        push(0, 0, 8'h01); push(1, 0, 8'h03); push(0, 0, 8'h03); push(1, 0, 8'h03);
`endif
        repeat (3) step();
        drv(0, 0, 2'b00, 0);
        step();
        drv(1, 0, 2'b00, 0);
        repeat (4) step();
        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/jk_bank_arbiter.md
Name: jk_bank_arbiter

Overview:
- Shares one bank of WIDTH JK flip-flop bits between NREQ requesters.
- Each requester issues single-bit JK commands over a valid/ready handshake: hold, clear, set or toggle one indexed bit.
- A round-robin arbiter picks one command per cycle. A one-deep apply stage then performs the JK update on the bank.
- Sits between control agents (counters, test sequencers, software registers) and the flag/state bits they share.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, number of JK bits in the bank (1..32).
- IDXW, $clog2(WIDTH) (minimum 1), width of a bit index.
- GIDW, $clog2(NREQ), width of a grant id.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  reset: synchronous, active-high.
- req_valid  input  NREQ  per-requester command valid.
- req_ready  output  NREQ  per-requester command accepted this cycle.
- req_jk  input  2*NREQ  per-requester {j,k}. Requester r uses bits [2r+1:2r].
- req_idx  input  IDXW*NREQ  per-requester target bit index, packed like req_jk.
- q_out  output  WIDTH  bank state.
- qb_out  output  WIDTH  bitwise inverse of q_out, combinational.
- gnt_id  output  GIDW  id of the requester accepted this cycle. Valid only when busy_apply is 1 on the following cycle.
- busy_apply  output  1  apply stage holds a command this cycle.
- idx_err  output  1  one-cycle pulse: a command with req_idx >= WIDTH was accepted and dropped.

Behaviour:
- Reset values:
  - q_out = 0, qb_out = all ones.
  - Round-robin pointer set so requester 0 has top priority.
  - Apply stage empty; busy_apply = 0, idx_err = 0, gnt_id = 0.
  - req_ready = 0 while rst = 1.
- Arbitration (combinational, every cycle rst = 0):
  - Search req_valid starting at pointer, wrapping modulo NREQ.
  - The first valid requester wins and sees req_ready = 1. All other ready bits are 0.
  - If no req_valid is set, no ready is asserted and the pointer is held.
- Handshake:
  - A transfer occurs on a rising edge with req_valid[r] = 1 and req_ready[r] = 1.
  - Requester must hold req_jk and req_idx stable while valid and not ready. The block does not check this.
  - A requester may deassert valid before acceptance without side effects.
- Pointer: after a transfer from requester r, pointer = (r+1) mod NREQ.
- Apply stage:
  - An accepted command is captured at edge E.
  - At edge E+1 the bit update takes place:
    - 00: hold, no change.
    - 01: q[idx] <= 0.
    - 10: q[idx] <= 1.
    - 11: q[idx] <= ~q[idx].
  - q_out reflects the result after edge E+1, i.e. one cycle after acceptance.
  - Throughput: one command per cycle. The stage never back-pressures, so ready depends only on arbitration.
- Same-bit back-to-back: commands to the same idx on consecutive cycles apply in acceptance order. The second sees the first's result (e.g. two toggles restore the original value).
- Out-of-range index (req_idx >= WIDTH):
  - Command is still accepted and the pointer still advances.
  - No bit changes.
  - idx_err pulses for the cycle in which the apply would have happened.
- Reset mid-operation: rst asserted while the apply stage is full discards the pending command. All state returns to reset values at that edge.
- Single FSM per apply stage: EMPTY <-> FULL, tracked by busy_apply.
  - EMPTY -> FULL on a transfer.
  - FULL -> FULL on a transfer.
  - FULL -> EMPTY when no transfer occurs.

Optional Feature:
- Macro JK_ARB_PRIO0_EN.
- Defined:
  - Requester 0 has fixed absolute priority. Whenever req_valid[0] = 1 it wins, regardless of pointer.
  - Grants to requester 0 do not move the pointer.
  - Remaining requesters are round-robin among themselves.
- Undefined: pure round-robin as described above.

Decomposition:
- Shared package jk_bank_pkg holds:
  - JK encoding constants: JK_HOLD = 2'b00, JK_CLR = 2'b01, JK_SET = 2'b10, JK_TGL = 2'b11.
  - The apply-stage state enum {ST_EMPTY, ST_FULL}.
- One sub-module, rr_arbiter, is natural. It is combinational plus the pointer register, parameterised by NREQ, with an input to mask pointer update for requester 0.
- The JK bit update stays inline in jk_bank_arbiter.

Test Plan:
1. Reset, then req0 sends {10, idx 3} for one accepted cycle. Required: q_out = 8'h08 one cycle after acceptance, qb_out = 8'hF7, idx_err = 0.
2. All four requesters valid continuously, each sending toggle to bit = its id. Required:
   - Grants in order 0,1,2,3,0.
   - After 4 acceptances plus 1 cycle, q_out = 8'h0F.
   - After the fifth, q_out = 8'h0E.
3. req1 sends set idx 5, then toggle idx 5, then toggle idx 5 on consecutive cycles. Required: q[5] sequence 1, 0, 1 on consecutive cycles. No gaps in req_ready[1].
4. req2 sends {11, idx 9} with WIDTH = 8. Required: accepted, idx_err pulses exactly one cycle, q_out unchanged, pointer advances to 3.
5. q_out = 8'hFF. Accept a clear on idx 0, then assert rst the next cycle. Required: after that edge q_out = 0, busy_apply = 0, and next arbitration favours req0.
6. With JK_ARB_PRIO0_EN defined, req0 and req1 both valid for 3 cycles. Required: req0 granted all 3 cycles. Once req0 drops, req1 is granted on the next cycle.
